seg14_digit_driver: RTL and testbench

//  Output stage between the 12-digit 14-segment scan multiplexer and the pads.

---
 rtl/seg14_digit_driver.sv | 123 ++++++++++++
 tb/tb_seg14_digit_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg14_digit_driver.sv
// seg14_digit_driver: output stage between the 14-segment scan mux and the pads.
//   Registers the mux's digit select and segment pattern, forces a dead-time blank
//   after every digit-select change (anti-ghosting), applies PWM brightness dimming
//   and flags non-one-hot selects with a sticky error.
// Latency: sel_in/segm_in -> sel_out/segm_out is 2 cycles when not blanked/dimmed.
// Backpressure: none; the pads are always accepting, the stage runs every cycle.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   sel_in   [DIGITS-1:0]  one-hot digit select from scan mux (0 = all off)
//   segm_in  [SEGS-1:0]    segment pattern for the selected digit
//   bright   [PWM_BITS-1:0], bright_we   brightness request and its write strobe
//   err_clr                clears the sticky err_onehot flag
//   sel_out, segm_out      registered pad drives
//   blanking               high exactly while dead-time forces the outputs off
//   err_onehot             sticky: a select with more than one bit set was sampled
//
// Build option: define SEG14_ACTIVE_LOW_EN for inverted (active-low) sel_out/segm_out;
// their reset/off value then becomes all-ones. blanking/err_onehot are unaffected.

module seg14_digit_driver #(
  parameter int DIGITS    = 12,
  parameter int SEGS      = 14,
  parameter int BLANK_CYC = 2,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGITS-1:0]   sel_in,
  input  logic [SEGS-1:0]     segm_in,
  input  logic [PWM_BITS-1:0] bright,
  input  logic                bright_we,
  input  logic                err_clr,
  output logic [DIGITS-1:0]   sel_out,
  output logic [SEGS-1:0]     segm_out,
  output logic                blanking,
  output logic                err_onehot
);

  localparam int BW = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYC);

  // "Off" level of the pad drives; XOR-ing with it also performs the inversion.
`ifdef SEG14_ACTIVE_LOW_EN
  localparam logic [DIGITS-1:0] SEL_OFF  = '1;
  localparam logic [SEGS-1:0]   SEGM_OFF = '1;
`else
  localparam logic [DIGITS-1:0] SEL_OFF  = '0;
  localparam logic [SEGS-1:0]   SEGM_OFF = '0;
`endif

  // Stage 1
  logic [DIGITS-1:0]   sel_q;
  logic [SEGS-1:0]     segm_q;
  logic                vld_q;
  logic                loaded;   // stage 1 holds a real sample (not the reset value)

  logic [BW-1:0]       blank_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  logic [PWM_BITS-1:0] bright_nxt;

  logic                sel_multi;
  logic                pwm_on;
  logic                drive_on;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign sel_multi = (sel_in & (sel_in - DIGITS'(1))) != '0;
  assign pwm_on    = (bright_q == '1) || (pwm_cnt < bright_q);
  assign drive_on  = (blank_cnt == '0) && vld_q && pwm_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      segm_q     <= '0;
      vld_q      <= 1'b0;
      loaded     <= 1'b0;
      blank_cnt  <= '0;
      pwm_cnt    <= '0;
      bright_q   <= '1;
      bright_nxt <= '1;
      err_onehot <= 1'b0;
      blanking   <= 1'b0;
      sel_out    <= SEL_OFF;
      segm_out   <= SEGM_OFF;
    end else begin
      sel_q  <= sel_in;
      segm_q <= segm_in;
      vld_q  <= !sel_multi;
      loaded <= 1'b1;

      // The first sample after reset is not a digit change: nothing was lit
      // before it, so there is no ghost to suppress.
      if (loaded && (sel_in != sel_q))
        blank_cnt <= BLANK_INIT;
      else if (blank_cnt != '0)
        blank_cnt <= blank_cnt - BW'(1);

      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (bright_we)
        bright_nxt <= bright;
      // Only adopt the new level at period end so a period is never split.
      if (pwm_cnt == '1)
        bright_q <= bright_nxt;

      // Set has priority over clear.
      if (sel_multi)
        err_onehot <= 1'b1;
      else if (err_clr)
        err_onehot <= 1'b0;

      blanking <= (blank_cnt != '0);
      if (drive_on) begin
        sel_out  <= sel_q ^ SEL_OFF;
        segm_out <= segm_q ^ SEGM_OFF;
      end else begin
        sel_out  <= SEL_OFF;
        segm_out <= SEGM_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg14_digit_driver.sv
// tb_seg14_digit_driver: directed vectors for seg14_digit_driver.
//   Each step drives one cycle of inputs and queues the output expected after the
//   edge that samples them; a monitor pops and compares after every edge.

module tb_seg14_digit_driver;

`ifdef SEG14_ACTIVE_LOW_EN
  localparam logic [11:0] INV_SEL  = 12'hFFF;
  localparam logic [13:0] INV_SEGM = 14'h3FFF;
`else
  localparam logic [11:0] INV_SEL  = 12'h000;
  localparam logic [13:0] INV_SEGM = 14'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sel_in;
  logic [13:0] segm_in;
  logic [3:0]  bright;
  logic        bright_we;
  logic        err_clr;
  logic [11:0] sel_out;
  logic [13:0] segm_out;
  logic        blanking;
  logic        err_onehot;

  seg14_digit_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_in     (sel_in),
    .segm_in    (segm_in),
    .bright     (bright),
    .bright_we  (bright_we),
    .err_clr    (err_clr),
    .sel_out    (sel_out),
    .segm_out   (segm_out),
    .blanking   (blanking),
    .err_onehot (err_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sel;
    logic [13:0] segm;
    logic        blank;
    logic        err;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs (also releases reset) and queue the expectation
  // for the output register after the edge that samples them.
  task automatic step(input logic [11:0] s, input logic [13:0] g,
                      input logic we, input logic [3:0] br, input logic clr,
                      input logic [11:0] es, input logic [13:0] eg,
                      input logic eb, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n     = 1'b1;
    sel_in    = s;
    segm_in   = g;
    bright_we = we;
    bright    = br;
    err_clr   = clr;
    e.sel = es; e.segm = eg; e.blank = eb; e.err = ee; e.nm = nm;
    sb.push_back(e);
  endtask

  // Steady digit 1 / pattern 1F00; outputs either lit or dark by PWM.
  task automatic run_pwm(input int n, input logic [3:0] br, input logic on, input string nm);
    for (int i = 0; i < n; i++)
      step(12'h001, 14'h1F00, 1'b0, br, 1'b0,
           on ? 12'h001 : 12'h000, on ? 14'h1F00 : 14'h0000, 1'b0, 1'b0, nm);
  endtask

  // Monitor: compare after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".sel"},   32'(sel_out),    32'(e.sel ^ INV_SEL));
        chk({e.nm, ".segm"},  32'(segm_out),   32'(e.segm ^ INV_SEGM));
        chk({e.nm, ".blank"}, 32'(blanking),   32'(e.blank));
        chk({e.nm, ".err"},   32'(err_onehot), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    sel_in    = 12'h001;
    segm_in   = 14'h3A00;
    bright    = 4'hF;
    bright_we = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.sel",   32'(sel_out),    32'(INV_SEL));
    chk("reset.segm",  32'(segm_out),   32'(INV_SEGM));
    chk("reset.blank", 32'(blanking),   32'h0);
    chk("reset.err",   32'(err_onehot), 32'h0);

    // Bring-up: first edge loads stage 1 without blanking, second edge drives.
    step(12'h001, 14'h3A00, 0, 4'hF, 0, 12'h000, 14'h0000, 0, 0, "up1");
    step(12'h001, 14'h3A00, 0, 4'hF, 0, 12'h001, 14'h3A00, 0, 0, "up2");
    step(12'h001, 14'h3A00, 0, 4'hF, 0, 12'h001, 14'h3A00, 0, 0, "up3");
    // Segment-only change: two-edge latency, no blank.
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h001, 14'h3A00, 0, 0, "segm1");
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h001, 14'h1F00, 0, 0, "segm2");
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h001, 14'h1F00, 0, 0, "segm3");
    // Select change: two dead-time cycles, then the new digit.
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h001, 14'h1F00, 0, 0, "chg_k");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 1, 0, "chg_k1");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 1, 0, "chg_k2");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h002, 14'h1F00, 0, 0, "chg_k3");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h002, 14'h1F00, 0, 0, "chg_k4");
    // Illegal select: sticky error, blank then dark because the select is invalid.
    step(12'h003, 14'h1F00, 0, 4'hF, 0, 12'h002, 14'h1F00, 0, 1, "bad1");
    step(12'h003, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 1, 1, "bad2");
    step(12'h003, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 1, 1, "bad3");
    step(12'h003, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 0, 1, "bad4");
    step(12'h003, 14'h1F00, 0, 4'hF, 1, 12'h000, 14'h0000, 0, 1, "setwins");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 0, 1, "sticky");
    step(12'h002, 14'h1F00, 0, 4'hF, 1, 12'h000, 14'h0000, 1, 0, "clr");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 1, 0, "rec1");
    step(12'h002, 14'h1F00, 0, 4'hF, 0, 12'h002, 14'h1F00, 0, 0, "rec2");
    // Enter a blank, then reset asynchronously in the middle of it.
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h002, 14'h1F00, 0, 0, "pre_rst");
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 1, 0, "mid_blank");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.sel",   32'(sel_out),  32'(INV_SEL));
    chk("async_rst.segm",  32'(segm_out), 32'(INV_SEGM));
    chk("async_rst.blank", 32'(blanking), 32'h0);

    // After release pwm_cnt restarts at 0; edge j sees pwm_cnt=(j-1)%16.
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h000, 14'h0000, 0, 0, "rel1");   // edge 1
    step(12'h001, 14'h1F00, 0, 4'hF, 0, 12'h001, 14'h1F00, 0, 0, "rel2");   // edge 2
    // bright=4 written at edge 3; full brightness holds through edge 16.
    step(12'h001, 14'h1F00, 1, 4'h4, 0, 12'h001, 14'h1F00, 0, 0, "we4");    // edge 3
    run_pwm(17, 4'h4, 1'b1, "pwm_old");   // edges 4..20 (17..20 are the 4 on-slots)
    run_pwm(12, 4'h4, 1'b0, "pwm4_off");  // edges 21..32
    run_pwm(4,  4'h4, 1'b1, "pwm4_on");   // edges 33..36
    // bright=0 at edge 37: rest of period at 4 (dark slots), then never on.
    step(12'h001, 14'h1F00, 1, 4'h0, 0, 12'h000, 14'h0000, 0, 0, "we0");    // edge 37
    run_pwm(27, 4'h0, 1'b0, "pwm0");      // edges 38..64
    // Pending 9 overwritten by 15 before the wrap; 15 means never off.
    step(12'h001, 14'h1F00, 1, 4'h9, 0, 12'h000, 14'h0000, 0, 0, "we9");    // edge 65
    step(12'h001, 14'h1F00, 1, 4'hF, 0, 12'h000, 14'h0000, 0, 0, "we15");   // edge 66
    run_pwm(14, 4'hF, 1'b0, "pwm0_tail"); // edges 67..80
    run_pwm(16, 4'hF, 1'b1, "pwm15");     // edges 81..96

    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
